// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared direction, slot and map-bound definitions for the projectile scheduler
package proj_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    localparam logic [11:0] MAP_MIN   = 12'd64;
    localparam logic [11:0] MAP_X_MAX = 12'd3136;
    localparam logic [11:0] MAP_Y_MAX = 12'd2336;

    typedef struct packed {
        logic        active;
        logic        owner;
        logic [11:0] x;
        logic [11:0] y;
        dir_t        dir;
    } slot_t;

    // true when a position lies outside the playable map; wrapped underflow lands high and fails too
    function automatic logic out_of_map(input logic [11:0] x, input logic [11:0] y);
        return (x < MAP_MIN) || (x > MAP_X_MAX) || (y < MAP_MIN) || (y > MAP_Y_MAX);
    endfunction

endpackage

// File: rtl/proj_slot.sv
// rtl/proj_slot.sv - one projectile slot: captures an allocation and moves it each frame
module proj_slot
    import proj_pkg::*;
#(
    parameter logic [11:0] SPEED = 12'd4
)(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_tick,
    input  logic        i_load,
    input  logic        i_owner,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  dir_t        i_dir,
    output slot_t       o_slot
);

    slot_t       r_slot;
    logic [11:0] w_nx;
    logic [11:0] w_ny;

    // candidate position one step along the travel direction, 12-bit wrapping
    always_comb begin
        w_nx = r_slot.x;
        w_ny = r_slot.y;
        case (r_slot.dir)
            DIR_N:   w_ny = r_slot.y - SPEED;
            DIR_S:   w_ny = r_slot.y + SPEED;
            DIR_E:   w_nx = r_slot.x + SPEED;
            default: w_nx = r_slot.x - SPEED;
        endcase
    end

    // active slots move or retire on a frame tick; idle slots accept a new shot
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_slot <= '0;
        end else if (r_slot.active) begin
            if (i_tick) begin
                if (out_of_map(w_nx, w_ny)) begin
                    r_slot <= '0;
                end else begin
                    r_slot.x <= w_nx;
                    r_slot.y <= w_ny;
                end
            end
        end else if (i_load) begin
            r_slot <= '{active: 1'b1, owner: i_owner, x: i_x, y: i_y, dir: i_dir};
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/projectile_scheduler.sv
// rtl/projectile_scheduler.sv - two-player shot arbitration over shared projectile slots (optional cooldown: PROJ_COOLDOWN_EN)
module projectile_scheduler
    import proj_pkg::*;
#(
    parameter int          NUM_SLOTS = 4,
    parameter logic [11:0] SPEED     = 12'd4,
    parameter logic [5:0]  COOLDOWN  = 6'd15
)(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_frame_tick,
    input  logic                   i_p1_fire,
    input  logic                   i_p2_fire,
    input  logic [11:0]            i_p1_x,
    input  logic [11:0]            i_p1_y,
    input  logic [11:0]            i_p2_x,
    input  logic [11:0]            i_p2_y,
    input  logic [1:0]             i_p1_dir,
    input  logic [1:0]             i_p2_dir,
    output logic [NUM_SLOTS-1:0]   o_slot_active,
    output logic [NUM_SLOTS-1:0]   o_slot_owner,
    output logic [NUM_SLOTS*12-1:0] o_slot_x,
    output logic [NUM_SLOTS*12-1:0] o_slot_y,
    output logic [NUM_SLOTS*2-1:0] o_slot_dir,
    output logic                   o_p1_grant,
    output logic                   o_p2_grant
);

    logic [1:0]           r_fire_prev;
    logic [1:0]           r_pend;
    logic [1:0]           r_grant;
    logic                 r_rr;          // 0: player 1 wins the next single-slot contention
    logic [1:0]           w_fire;
    logic [1:0]           w_edge;
    logic [1:0]           w_cd_zero;
    logic [1:0]           w_grant;
    logic                 w_p2_second;
    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_first;
    logic [NUM_SLOTS-1:0] w_second;
    logic [NUM_SLOTS-1:0] w_p1_mask;
    logic [NUM_SLOTS-1:0] w_p2_mask;
    slot_t                w_slot [NUM_SLOTS];

    assign w_fire = {i_p2_fire, i_p1_fire};
    assign w_edge = w_fire & ~r_fire_prev;

    // one-hot masks of the lowest and second-lowest idle slots
    always_comb begin
        w_first  = '0;
        w_second = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (w_free[i]) begin
                if (w_first == '0) begin
                    w_first[i] = 1'b1;
                end else if (w_second == '0) begin
                    w_second[i] = 1'b1;
                end
            end
        end
    end

    // decide who is served this cycle; player 1 always takes the lower slot when both fit
    always_comb begin
        w_grant     = 2'b00;
        w_p2_second = 1'b0;
        if (w_first != '0) begin
            if (&r_pend) begin
                if (w_second != '0) begin
                    w_grant     = 2'b11;
                    w_p2_second = 1'b1;
                end else begin
                    w_grant = r_rr ? 2'b10 : 2'b01;
                end
            end else begin
                w_grant = r_pend;
            end
        end
    end

    assign w_p1_mask = w_grant[0] ? w_first : '0;
    assign w_p2_mask = !w_grant[1] ? '0 : (w_p2_second ? w_second : w_first);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        proj_slot #(.SPEED(SPEED)) u_slot (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_tick  (i_frame_tick),
            .i_load  (w_p1_mask[g] | w_p2_mask[g]),
            .i_owner (w_p2_mask[g]),
            .i_x     (w_p2_mask[g] ? i_p2_x : i_p1_x),
            .i_y     (w_p2_mask[g] ? i_p2_y : i_p1_y),
            .i_dir   (dir_t'(w_p2_mask[g] ? i_p2_dir : i_p1_dir)),
            .o_slot  (w_slot[g])
        );
        assign w_free[g]             = ~w_slot[g].active;
        assign o_slot_active[g]      = w_slot[g].active;
        assign o_slot_owner[g]       = w_slot[g].owner;
        assign o_slot_x[g*12 +: 12]  = w_slot[g].x;
        assign o_slot_y[g*12 +: 12]  = w_slot[g].y;
        assign o_slot_dir[g*2 +: 2]  = w_slot[g].dir;
    end

`ifdef PROJ_COOLDOWN_EN
    logic [1:0][5:0] r_cd;

    // reload on grant, otherwise count down once per frame and stop at zero
    always_ff @(posedge i_clk) begin
        for (int p = 0; p < 2; p++) begin
            if (i_reset) begin
                r_cd[p] <= '0;
            end else if (w_grant[p]) begin
                r_cd[p] <= COOLDOWN;
            end else if (i_frame_tick && (r_cd[p] != '0)) begin
                r_cd[p] <= r_cd[p] - 6'd1;
            end
        end
    end

    assign w_cd_zero = {(r_cd[1] == '0), (r_cd[0] == '0)};
`else
    // cooldown compiled out: players may always fire; the parameter stays on the interface
    logic w_cooldown_unused;
    assign w_cooldown_unused = ^COOLDOWN;
    assign w_cd_zero         = 2'b11;
`endif

    // edge history, pending requests, grant pulses and the contention pointer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fire_prev <= 2'b00;
            r_pend      <= 2'b00;
            r_grant     <= 2'b00;
            r_rr        <= 1'b0;
        end else begin
            r_fire_prev <= w_fire;
            r_grant     <= w_grant;
            r_pend      <= (r_pend & ~w_grant) | (w_edge & w_cd_zero & ~r_pend);
            if ((&r_pend) && (w_first != '0) && (w_second == '0)) begin
                r_rr <= ~r_rr;
            end
        end
    end

    assign o_p1_grant = r_grant[0];
    assign o_p2_grant = r_grant[1];

endmodule

// File: tb/tb_projectile_scheduler.sv
// tb/tb_projectile_scheduler.sv - directed and randomized checks of projectile_scheduler against a reference model
module tb_projectile_scheduler;

    localparam int NS      = 4;
    localparam int SPD     = 4;
    localparam int CD_LOAD = 15;
`ifdef PROJ_COOLDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              tick;
    logic              f1, f2;
    logic [11:0]       x1, y1, x2, y2;
    logic [1:0]        d1, d2;
    logic [NS-1:0]     o_act, o_own;
    logic [NS*12-1:0]  o_x, o_y;
    logic [NS*2-1:0]   o_dir;
    logic              o_g1, o_g2;

    int n_tests = 0;
    int n_fail  = 0;

    projectile_scheduler dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_frame_tick  (tick),
        .i_p1_fire     (f1),
        .i_p2_fire     (f2),
        .i_p1_x        (x1),
        .i_p1_y        (y1),
        .i_p2_x        (x2),
        .i_p2_y        (y2),
        .i_p1_dir      (d1),
        .i_p2_dir      (d2),
        .o_slot_active (o_act),
        .o_slot_owner  (o_own),
        .o_slot_x      (o_x),
        .o_slot_y      (o_y),
        .o_slot_dir    (o_dir),
        .o_p1_grant    (o_g1),
        .o_p2_grant    (o_g2)
    );

    always #5 clk = ~clk;

    // reference model state
    bit m_act [NS];
    bit m_own [NS];
    int m_x   [NS];
    int m_y   [NS];
    int m_dir [NS];
    bit m_pend[2];
    int m_cd  [2];
    bit m_prev[2];
    bit m_g   [2];
    int m_rr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance the model by one clock using the inputs presented for this edge
    task automatic model_edge();
        int free_q[$];
        bit g[2];
        int gi[2];
        bit fire[2];
        int px[2], py[2], pd[2];
        int nx, ny;
        bit ed_seen, cd_ok;
        fire[0] = f1; fire[1] = f2;
        px[0] = int'(x1); px[1] = int'(x2);
        py[0] = int'(y1); py[1] = int'(y2);
        pd[0] = int'(d1); pd[1] = int'(d2);
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_act[i] = 0; m_own[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
            end
            for (int p = 0; p < 2; p++) begin
                m_pend[p] = 0; m_cd[p] = 0; m_prev[p] = 0; m_g[p] = 0;
            end
            m_rr = 0;
            return;
        end
        for (int i = 0; i < NS; i++) if (!m_act[i]) free_q.push_back(i);
        g[0] = 0; g[1] = 0; gi[0] = 0; gi[1] = 0;
        if (m_pend[0] && m_pend[1]) begin
            if (free_q.size() >= 2) begin
                g[0] = 1; g[1] = 1; gi[0] = free_q[0]; gi[1] = free_q[1];
            end else if (free_q.size() == 1) begin
                g[m_rr] = 1; gi[m_rr] = free_q[0]; m_rr = 1 - m_rr;
            end
        end else begin
            for (int p = 0; p < 2; p++)
                if (m_pend[p] && free_q.size() > 0) begin g[p] = 1; gi[p] = free_q[0]; end
        end
        if (tick) begin
            for (int i = 0; i < NS; i++) begin
                if (m_act[i]) begin
                    nx = m_x[i]; ny = m_y[i];
                    case (m_dir[i])
                        0: ny = ny - SPD;
                        1: ny = ny + SPD;
                        2: nx = nx + SPD;
                        default: nx = nx - SPD;
                    endcase
                    nx = (nx + 4096) % 4096;
                    ny = (ny + 4096) % 4096;
                    if (nx < 64 || nx > 3136 || ny < 64 || ny > 2336) begin
                        m_act[i] = 0; m_own[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
                    end else begin
                        m_x[i] = nx; m_y[i] = ny;
                    end
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (g[p]) begin
                m_act[gi[p]] = 1; m_own[gi[p]] = (p == 1);
                m_x[gi[p]] = px[p]; m_y[gi[p]] = py[p]; m_dir[gi[p]] = pd[p];
            end
        end
        for (int p = 0; p < 2; p++) begin
            ed_seen = fire[p] && !m_prev[p];
            cd_ok   = (m_cd[p] == 0);
            if (g[p]) begin
                m_pend[p] = 0;
                m_cd[p]   = CD_EN ? CD_LOAD : 0;
            end else begin
                if (ed_seen && cd_ok && !m_pend[p]) m_pend[p] = 1;
                if (tick && m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
            end
            m_prev[p] = fire[p];
            m_g[p]    = g[p];
        end
    endtask

    task automatic compare();
        logic [NS-1:0]    ea, eo;
        logic [NS*12-1:0] ex, ey;
        logic [NS*2-1:0]  ed;
        for (int i = 0; i < NS; i++) begin
            ea[i] = m_act[i];
            eo[i] = m_own[i];
            ex[i*12 +: 12] = 12'(m_x[i]);
            ey[i*12 +: 12] = 12'(m_y[i]);
            ed[i*2 +: 2]   = 2'(m_dir[i]);
        end
        check("p1_grant", 128'(o_g1), 128'(m_g[0]));
        check("p2_grant", 128'(o_g2), 128'(m_g[1]));
        check("active",   128'(o_act), 128'(ea));
        check("owner",    128'(o_own), 128'(eo));
        check("slot_x",   128'(o_x), 128'(ex));
        check("slot_y",   128'(o_y), 128'(ey));
        check("slot_dir", 128'(o_dir), 128'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1; f1 = 1'b0; f2 = 1'b0; tick = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
    endtask

    function automatic logic [11:0] pick(input int hi);
        case ($urandom_range(0, 3))
            0: return 12'($urandom_range(64, 76));
            1: return 12'($urandom_range(hi - 12, hi));
            2: return 12'($urandom_range(0, 4095));
            default: return 12'($urandom_range(64, hi));
        endcase
    endfunction

    initial begin
        rst = 1'b1; tick = 1'b0; f1 = 1'b0; f2 = 1'b0;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0; d1 = '0; d2 = '0;

        // reset state
        do_reset();
        check("rst_active", 128'(o_act), 128'(0));
        check("rst_grants", 128'({o_g1, o_g2}), 128'(0));

        // single shot travelling east for three frames
        x1 = 12'd700; y1 = 12'd700; d1 = 2'd2;
        f1 = 1'b1; step(); step();
        check("r033_grant", 128'(o_g1), 128'(1));
        check("r033_x0", 128'(o_x[11:0]), 128'(700));
        f1 = 1'b0; step();
        frames(3);
        check("r033_x3", 128'(o_x[11:0]), 128'(712));

        // simultaneous fire with all slots free
        do_reset();
        x1 = 12'd1000; y1 = 12'd1000; d1 = 2'd2;
        x2 = 12'd1000; y2 = 12'd1200; d2 = 2'd3;
        f1 = 1'b1; f2 = 1'b1; step(); step();
        check("r034_grants", 128'({o_g1, o_g2}), 128'(3));
        check("r034_owner", 128'(o_own[1:0]), 128'(2));
        f1 = 1'b0; f2 = 1'b0; step();

        // boundary retirement going north and east
        do_reset();
        x1 = 12'd3000; y1 = 12'd66; d1 = 2'd0;
        x2 = 12'd3134; y2 = 12'd1000; d2 = 2'd2;
        f1 = 1'b1; f2 = 1'b1; step(); step();
        check("r036_live", 128'(o_act), 128'(3));
        f1 = 1'b0; f2 = 1'b0; step();
        tick = 1'b1; step(); tick = 1'b0;
        check("r036_clear", 128'(o_act), 128'(0));

        // contention for the last slot and round-robin hand-over
        do_reset();
        x1 = 12'd1000; y1 = 12'd1000; d1 = 2'd2;
        x2 = 12'd1000; y2 = 12'd1200; d2 = 2'd2;
        f1 = 1'b1; f2 = 1'b1; step(); step();
        f1 = 1'b0; f2 = 1'b0; step();
        x1 = 12'd3134; y1 = 12'd500;
        f1 = 1'b1; step(); step();
        f1 = 1'b0; step();
        x1 = 12'd1500; y1 = 12'd1500;
        x2 = 12'd3134; y2 = 12'd600;
        f1 = 1'b1; f2 = 1'b1; step(); step();
        check("r035_first", 128'({o_g2, o_g1}), 128'(1));
        check("r035_full", 128'(o_act), 128'(15));
        f1 = 1'b0; f2 = 1'b0; step(); step();
        tick = 1'b1; step(); tick = 1'b0;
        check("r035_freed", 128'(o_act), 128'(11));
        check("r035_nosame", 128'(o_g2), 128'(0));
        step();
        check("r035_p2late", 128'(o_g2), 128'(1));
        check("r035_owner2", 128'(o_own[2]), 128'(1));
        f1 = 1'b1; f2 = 1'b1; step(); step();
        check("r035_held", 128'({o_g2, o_g1}), 128'(0));
        tick = 1'b1; step(); tick = 1'b0;
        step();
        check("r035_rr", 128'({o_g2, o_g1}), 128'(2));
        f1 = 1'b0; f2 = 1'b0;
        tick = 1'b1; step(); tick = 1'b0;
        step();
        check("r035_p1after", 128'({o_g2, o_g1}), 128'(1));

        // reset with live slots and a pending request
        do_reset();
        x1 = 12'd1000; y1 = 12'd1000; d1 = 2'd1;
        x2 = 12'd2000; y2 = 12'd1000; d2 = 2'd1;
        f1 = 1'b1; f2 = 1'b1; step(); step();
        f1 = 1'b0; f2 = 1'b0; step();
        f2 = 1'b1; step();
        rst = 1'b1; f2 = 1'b0; step();
        check("r038_act", 128'(o_act), 128'(0));
        rst = 1'b0;
        repeat (4) step();
        check("r038_nogrant", 128'({o_g1, o_g2}), 128'(0));
        check("r038_idle", 128'(o_act), 128'(0));

        // re-fire during and after cooldown
        do_reset();
        x1 = 12'd1500; y1 = 12'd1500; d1 = 2'd2;
        f1 = 1'b1; step(); step();
        check("r037_first", 128'(o_g1), 128'(1));
        f1 = 1'b0; step();
        frames(5);
        f1 = 1'b1; step(); step();
        check("r037_early", 128'(o_g1), 128'(!CD_EN));
        f1 = 1'b0; step();
        frames(10);
        f1 = 1'b1; step(); step();
        check("r037_t15", 128'(o_g1), 128'(1));
        f1 = 1'b0; step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) f1 = ~f1;
            if ($urandom_range(0, 2) == 0) f2 = ~f2;
            x1 = pick(3136); y1 = pick(2336); d1 = 2'($urandom_range(0, 3));
            x2 = pick(3136); y2 = pick(2336); d2 = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
